// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, flag bit positions and FSM encoding.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_NOT  = 4'h5;
  localparam logic [3:0] OP_SHL  = 4'h6;
  localparam logic [3:0] OP_SHR  = 4'h7;
  localparam logic [3:0] OP_SRA  = 4'h8;
  localparam logic [3:0] OP_INC  = 4'h9;
  localparam logic [3:0] OP_DEC  = 4'hA;
  localparam logic [3:0] OP_CMP  = 4'hB;
  localparam logic [3:0] OP_MUL  = 4'hC;
  localparam logic [3:0] OP_MULH = 4'hD;

  // Positions inside the {C,Z,N,V} flags vector.
  localparam int FLG_C = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_N = 1;
  localparam int FLG_V = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result bundle of alu_seq: input valid/ready handshake plus result, flags and busy.
interface alu_seq_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       s;
  logic             out_valid;
  logic [WIDTH-1:0] alu_out;
  logic [3:0]       flags;
  logic             busy;

  modport master (
    output in_valid, A, B, s,
    input  in_ready, out_valid, alu_out, flags, busy
  );

  modport slave (
    input  in_valid, A, B, s,
    output in_ready, out_valid, alu_out, flags, busy
  );
endinterface

// File: rtl/alu_mul_seq.sv
// Shift-add unsigned multiplier: one iteration per clock after start, product valid with done.
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int SHW = $clog2(WIDTH);

  logic                 running;
  logic [SHW-1:0]       cnt;
  logic [WIDTH-1:0]     mcand;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   acc_next;

  // Upper half accumulates partial sums; lower half starts as the multiplier and shifts out.
  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    acc_next = {sum, acc[WIDTH-1:1]};
  end

  assign done    = running && (cnt == SHW'(WIDTH - 1));
  assign product = acc_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      running <= 1'b0;
      cnt     <= '0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
    end else if (running) begin
      cnt <= cnt + 1'b1;
      if (done) running <= 1'b0;
    end
  end

  // NOTE: datapath registers carry no reset; running gates every use of them.
  always_ff @(posedge clk) begin
    if (start) begin
      mcand <= a;
      acc   <= {{WIDTH{1'b0}}, b};
    end else if (running) begin
      acc <= acc_next;
    end
  end
endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready input, {C,Z,N,V} flags and multi-cycle MUL/MULH.
// Define ALU_SAT_EN to saturate ADD/SUB/INC/DEC on signed overflow instead of wrapping.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic      clk,
  input logic      reset,
  alu_seq_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  state_t             state, state_next;
  logic               accept, is_mul_op, mul_done, mulh_q;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   opb, sat_val, res, zsrc, mul_res, mul_hi;
  logic [WIDTH:0]     add_w, sub_w, shl_w, shr_w, sra_w;
  logic [SHW-1:0]     amt;
  logic               add_v, sub_v, carry, ovf;
  logic [3:0]         flg, mul_flg;

  assign is_mul_op = (bus.s == OP_MUL) || (bus.s == OP_MULH);
  assign accept    = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept && is_mul_op) state_next = ST_MUL;
      ST_MUL:  if (mul_done)            state_next = ST_IDLE;
      default:                          state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready = (state == ST_IDLE);
    bus.busy     = (state == ST_MUL);
  end

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (accept && is_mul_op),
    .a       (bus.A),
    .b       (bus.B),
    .done    (mul_done),
    .product (product)
  );

  // Shared adder/subtractor: INC/DEC reuse it with a constant 1 operand.
  always_comb begin
    opb     = (bus.s == OP_INC || bus.s == OP_DEC) ? {{(WIDTH-1){1'b0}}, 1'b1} : bus.B;
    amt     = bus.B[SHW-1:0];
    add_w   = {1'b0, bus.A} + {1'b0, opb};
    sub_w   = {1'b0, bus.A} - {1'b0, opb};
    add_v   = (bus.A[WIDTH-1] == opb[WIDTH-1]) && (add_w[WIDTH-1] != bus.A[WIDTH-1]);
    sub_v   = (bus.A[WIDTH-1] != opb[WIDTH-1]) && (sub_w[WIDTH-1] != bus.A[WIDTH-1]);
    sat_val = bus.A[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    // The extra bit on each side catches the last bit shifted out; it stays 0 for amt==0.
    shl_w   = {1'b0, bus.A} << amt;
    shr_w   = {bus.A, 1'b0} >> amt;
    sra_w   = $unsigned($signed({bus.A, 1'b0}) >>> amt);
  end

  // NOTE: every output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    res   = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    case (bus.s)
      OP_ADD, OP_INC: begin res = add_w[WIDTH-1:0]; carry = add_w[WIDTH]; ovf = add_v; end
      OP_SUB, OP_DEC: begin res = sub_w[WIDTH-1:0]; carry = sub_w[WIDTH]; ovf = sub_v; end
      OP_CMP:         begin carry = sub_w[WIDTH]; ovf = sub_v; end
      OP_AND:         res = bus.A & bus.B;
      OP_OR:          res = bus.A | bus.B;
      OP_XOR:         res = bus.A ^ bus.B;
      OP_NOT:         res = ~bus.A;
      OP_SHL:         begin res = shl_w[WIDTH-1:0]; carry = shl_w[WIDTH]; end
      OP_SHR:         begin res = shr_w[WIDTH:1];   carry = shr_w[0];     end
      OP_SRA:         begin res = sra_w[WIDTH:1];   carry = sra_w[0];     end
      default:        res = '0;
    endcase
`ifdef ALU_SAT_EN
    if (ovf && bus.s != OP_CMP) res = sat_val;
`endif
    zsrc       = (bus.s == OP_CMP) ? sub_w[WIDTH-1:0] : res;
    flg        = '0;
    flg[FLG_C] = carry;
    flg[FLG_Z] = (zsrc == '0);
    flg[FLG_N] = zsrc[WIDTH-1];
    flg[FLG_V] = ovf;
  end

  always_comb begin
    mul_hi         = product[2*WIDTH-1:WIDTH];
    mul_res        = mulh_q ? mul_hi : product[WIDTH-1:0];
    mul_flg        = '0;
    mul_flg[FLG_Z] = (mul_res == '0);
    mul_flg[FLG_N] = mul_res[WIDTH-1];
    mul_flg[FLG_V] = !mulh_q && (mul_hi != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.alu_out   <= '0;
      bus.flags     <= '0;
      mulh_q        <= 1'b0;
    end else begin
      bus.out_valid <= 1'b0;
      if (accept) mulh_q <= (bus.s == OP_MULH);
      if (accept && !is_mul_op) begin
        bus.alu_out   <= res;
        bus.flags     <= flg;
        bus.out_valid <= 1'b1;
      end else if (state == ST_MUL && mul_done) begin
        bus.alu_out   <= mul_res;
        bus.flags     <= mul_flg;
        bus.out_valid <= 1'b1;
      end
    end
  end
endmodule
